// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//   Captures the core's retirement stream into a first-word-fall-through
//   FIFO so a debug/difftest host can drain it over a valid/ready port.
//   Each entry is tagged with a free-running commit sequence number, so a
//   gap in trace_seq at the host marks dropped commits.
//
// Optional feature: define COMMIT_TRACE_FLOW_CHECK_EN to enable the PC-flow
//   continuity check (commit_pc must equal the previous commit's pre_pc).
//   When it is undefined, flow_err and flow_err_pc are tied to 0.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   commit, commit_*    : retirement stream from write-back
//   trace_clr           : synchronous flush of FIFO, flags and drop counter
//   trace_valid/ready   : head handshake to the host
//   trace_pc/instr/pre_pc/seq : head entry fields
//   fifo_count          : current occupancy
//   overflow, drop_cnt  : sticky drop flag, saturating drop counter
//   flow_err, flow_err_pc : sticky PC discontinuity flag and first bad PC
module commit_trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit,
    input  logic [31:0]              commit_instr,
    input  logic [63:0]              commit_pc,
    input  logic [63:0]              commit_pre_pc,
    input  logic                     trace_clr,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [63:0]              trace_pc,
    output logic [31:0]              trace_instr,
    output logic [63:0]              trace_pre_pc,
    output logic [SEQ_W-1:0]         trace_seq,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     flow_err,
    output logic [63:0]              flow_err_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [63:0]      pc;
        logic [31:0]      instr;
        logic [63:0]      pre_pc;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            last_q;     // last entry popped; shown while empty
    entry_t            head;
    entry_t            wr_entry;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_q;
    logic [SEQ_W-1:0]  seq_q;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_q;
    logic              empty, full, pop, push, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // trace_clr discards both the same-cycle pop and push.
    assign pop  = !empty && trace_ready && !trace_clr;
    assign push = commit && !trace_clr && (!full || pop);
    assign drop = commit && !trace_clr && full && !pop;

    assign wr_entry = '{pc: commit_pc, instr: commit_instr,
                        pre_pc: commit_pre_pc, seq: seq_q};

    // Storage array carries no reset; the head mux never exposes an
    // unwritten slot because empty selects last_q instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            last_q     <= '0;
        end else begin
            // Sequence number advances on every commit, kept or not.
            if (commit) seq_q <= seq_q + 1'b1;

            if (trace_clr) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
                drop_q     <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    last_q <= mem[rd_ptr];
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
                if (drop) begin
                    overflow_q <= 1'b1;
                    if (drop_q != '1) drop_q <= drop_q + 1'b1;
                end
            end
        end
    end

    assign head         = empty ? last_q : mem[rd_ptr];
    assign trace_valid  = !empty;
    assign trace_pc     = head.pc;
    assign trace_instr  = head.instr;
    assign trace_pre_pc = head.pre_pc;
    assign trace_seq    = head.seq;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_q;

`ifdef COMMIT_TRACE_FLOW_CHECK_EN
    logic [63:0] last_pre_pc;
    logic        have_prev;
    logic        flow_err_q;
    logic [63:0] flow_err_pc_q;

    // Every commit (including dropped ones) is checked against the previous
    // commit's predicted next PC; a clear restarts history so the first
    // commit afterwards is never flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pre_pc   <= '0;
            have_prev     <= 1'b0;
            flow_err_q    <= 1'b0;
            flow_err_pc_q <= '0;
        end else if (trace_clr) begin
            last_pre_pc   <= '0;
            have_prev     <= 1'b0;
            flow_err_q    <= 1'b0;
            flow_err_pc_q <= '0;
        end else if (commit) begin
            if (have_prev && (commit_pc != last_pre_pc)) begin
                if (!flow_err_q) flow_err_pc_q <= commit_pc;
                flow_err_q <= 1'b1;
            end
            last_pre_pc <= commit_pre_pc;
            have_prev   <= 1'b1;
        end
    end

    assign flow_err    = flow_err_q;
    assign flow_err_pc = flow_err_pc_q;
`else
    assign flow_err    = 1'b0;
    assign flow_err_pc = '0;
`endif

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo (DEPTH=8, SEQ_W=32, DROP_W=16).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at that same point, i.e. well away from the next active edge.
module tb_commit_trace_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit = 1'b0;
    logic [31:0] commit_instr = '0;
    logic [63:0] commit_pc = '0;
    logic [63:0] commit_pre_pc = '0;
    logic        trace_clr = 1'b0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [63:0] trace_pc;
    logic [31:0] trace_instr;
    logic [63:0] trace_pre_pc;
    logic [31:0] trace_seq;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        flow_err;
    logic [63:0] flow_err_pc;

    commit_trace_fifo #(.DEPTH(8), .SEQ_W(32), .DROP_W(16)) dut (
        .clk(clk), .rst(rst), .commit(commit), .commit_instr(commit_instr),
        .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc),
        .trace_clr(trace_clr), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_instr(trace_instr), .trace_pre_pc(trace_pre_pc),
        .trace_seq(trace_seq), .fifo_count(fifo_count),
        .overflow(overflow), .drop_cnt(drop_cnt), .flow_err(flow_err),
        .flow_err_pc(flow_err_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] pre);
        commit = 1'b1; commit_pc = pc; commit_instr = ins; commit_pre_pc = pre;
        step();
        commit = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b0; commit = 1'b0; trace_clr = 1'b0; trace_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    typedef struct { logic [31:0] seq; logic [63:0] pc; } exp_t;
    exp_t        q[$];
    logic [31:0] mseq;
    logic        prev_stall;
    logic [63:0] prev_pc;
    logic [31:0] prev_seq;

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_valid", 64'(trace_valid), 0);
        chk("rst_count", 64'(fifo_count), 0);
        chk("rst_seq",   64'(trace_seq), 0);
        chk("rst_pc",    trace_pc, 0);
        chk("rst_ovf",   64'(overflow), 0);
        chk("rst_drop",  64'(drop_cnt), 0);
        chk("rst_flow",  64'(flow_err), 0);
        reset_dut();

        // ---- single commit, then pop; head keeps last-read entry ----
        push_one(64'h8000_0000, 32'h0000_0013, 64'h8000_0004);
        chk("t1_valid", 64'(trace_valid), 1);
        chk("t1_pc",    trace_pc, 64'h8000_0000);
        chk("t1_instr", 64'(trace_instr), 64'h13);
        chk("t1_pre",   trace_pre_pc, 64'h8000_0004);
        chk("t1_seq",   64'(trace_seq), 0);
        chk("t1_count", 64'(fifo_count), 1);
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
        chk("t1_empty",   64'(trace_valid), 0);
        chk("t1_lastpc",  trace_pc, 64'h8000_0000);
        chk("t1_count0",  64'(fifo_count), 0);

        // ---- burst of 10 into DEPTH 8 ----
        reset_dut();
        for (int i = 0; i < 10; i++)
            push_one(64'h100 + 64'(4*i), 32'(i), 64'h104 + 64'(4*i));
        chk("burst_count", 64'(fifo_count), 8);
        chk("burst_ovf",   64'(overflow), 1);
        chk("burst_drop",  64'(drop_cnt), 2);
        chk("burst_seq0",  64'(trace_seq), 0);
        chk("burst_pc0",   trace_pc, 64'h100);
        // full + pop + commit on the same edge: accepted, gets seq 10
        trace_ready = 1'b1;
        push_one(64'h500, 32'h55, 64'h504);
        chk("full_pp_count", 64'(fifo_count), 8);
        chk("full_pp_drop",  64'(drop_cnt), 2);
        for (int i = 1; i < 9; i++) begin
            chk("drain_valid", 64'(trace_valid), 1);
            chk("drain_seq", 64'(trace_seq), (i == 8) ? 64'd10 : 64'(i));
            chk("drain_pc",  trace_pc, (i == 8) ? 64'h500 : 64'h100 + 64'(4*i));
            step();
        end
        trace_ready = 1'b0;
        chk("drain_empty", 64'(trace_valid), 0);
        mseq = 32'd11;

        // ---- back-pressure with continuous stream ----
        prev_stall = 1'b0; prev_pc = '0; prev_seq = '0;
        for (int i = 0; i < 12; i++) begin
            commit = 1'b1;
            commit_pc = 64'h4000 + 64'(8*i);
            commit_instr = 32'(i);
            commit_pre_pc = 64'h4000 + 64'(8*i) + 64'd8;
            trace_ready = i[0];
            if (prev_stall) begin
                chk("bp_hold_pc",  trace_pc, prev_pc);
                chk("bp_hold_seq", 64'(trace_seq), 64'(prev_seq));
            end
            if (trace_valid && trace_ready) begin
                if (q.size() == 0) chk("bp_extra", 1, 0);
                else begin
                    chk("bp_seq", 64'(trace_seq), 64'(q[0].seq));
                    chk("bp_pc",  trace_pc, q[0].pc);
                    void'(q.pop_front());
                end
            end
            prev_stall = trace_valid && !trace_ready;
            prev_pc = trace_pc; prev_seq = trace_seq;
            q.push_back('{seq: mseq, pc: commit_pc});
            mseq++;
            step();
        end
        commit = 1'b0;
        trace_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            chk("bp_dvalid", 64'(trace_valid), 1);
            chk("bp_dseq", 64'(trace_seq), 64'(q[0].seq));
            chk("bp_dpc",  trace_pc, q[0].pc);
            void'(q.pop_front());
            step();
        end
        trace_ready = 1'b0;
        chk("bp_left",  64'(q.size()), 0);
        chk("bp_empty", 64'(trace_valid), 0);

        // ---- flow check ----
        reset_dut();
        push_one(64'h1000, 32'h1, 64'h1004);
        push_one(64'h1004, 32'h2, 64'h1008);
        chk("flow_ok", 64'(flow_err), 0);
        push_one(64'h2000, 32'h3, 64'h2004);
`ifdef COMMIT_TRACE_FLOW_CHECK_EN
        chk("flow_err1", 64'(flow_err), 1);
        chk("flow_pc1",  flow_err_pc, 64'h2000);
`else
        chk("flow_off",    64'(flow_err), 0);
        chk("flow_pc_off", flow_err_pc, 0);
`endif
        push_one(64'h3000, 32'h4, 64'h3004);
`ifdef COMMIT_TRACE_FLOW_CHECK_EN
        chk("flow_first", flow_err_pc, 64'h2000);
`else
        chk("flow_pc_off2", flow_err_pc, 0);
`endif
        trace_clr = 1'b1;
        step();
        trace_clr = 1'b0;
        chk("flow_clr_err", 64'(flow_err), 0);
        chk("flow_clr_pc",  flow_err_pc, 0);
        chk("flow_clr_cnt", 64'(fifo_count), 0);

        // ---- trace_clr with concurrent commit, then async reset ----
        reset_dut();
        for (int i = 0; i < 3; i++)
            push_one(64'h6000 + 64'(4*i), 32'(i), 64'h6004 + 64'(4*i));
        chk("clr_pre_cnt", 64'(fifo_count), 3);
        trace_clr = 1'b1;
        push_one(64'h7000, 32'h77, 64'h7004);   // seq 3, discarded
        trace_clr = 1'b0;
        chk("clr_cnt",   64'(fifo_count), 0);
        chk("clr_ovf",   64'(overflow), 0);
        chk("clr_drop",  64'(drop_cnt), 0);
        chk("clr_valid", 64'(trace_valid), 0);
        push_one(64'h7100, 32'h78, 64'h7104);
        chk("clr_seq_adv", 64'(trace_seq), 4);
        chk("clr_pc",      trace_pc, 64'h7100);
        commit = 1'b1; commit_pc = 64'h7200;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(trace_valid), 0);
        chk("arst_seq",   64'(trace_seq), 0);
        chk("arst_pc",    trace_pc, 0);
        chk("arst_instr", 64'(trace_instr), 0);
        chk("arst_count", 64'(fifo_count), 0);
        commit = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Consumes the retirement stream from the write-back end of the 5-stage RV64 core: commit, commit_instr, commit_pc, commit_pre_pc.
- Buffers each retired instruction into a first-word-fall-through FIFO, tagged with a sequence number, for a debug/difftest host to drain over a valid/ready port.
- Tracks overflow drops and, optionally, PC-flow continuity between consecutive commits.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of 2 and at least 2.
- SEQ_W, 32, width of the commit sequence number.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- commit  in  1  one instruction retires this cycle.
- commit_instr  in  32  retired instruction word.
- commit_pc  in  64  PC of the retired instruction.
- commit_pre_pc  in  64  next PC predicted at fetch for the retired instruction.
- trace_clr  in  1  synchronous flush of FIFO, flags and drop counter.
- trace_valid  out  1  head entry is available.
- trace_ready  in  1  host accepts the head entry.
- trace_pc  out  64  head entry PC.
- trace_instr  out  32  head entry instruction word.
- trace_pre_pc  out  64  head entry predicted next PC.
- trace_seq  out  SEQ_W  head entry sequence number.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one commit was dropped.
- drop_cnt  out  DROP_W  number of dropped commits, saturating.
- flow_err  out  1  sticky: PC discontinuity detected.
- flow_err_pc  out  64  commit_pc of the first discontinuity.

Behaviour:
- Reset (rst=0, async): all outputs, pointers, counters and flags are 0; the FIFO is empty. Release is registered, so the first commit is accepted at the first clk edge with rst=1.
- Push: on a clk edge with commit=1, the entry {commit_pc, commit_instr, commit_pre_pc, seq} is written.
  - Latency is 1: the entry is visible at the head the cycle after the write edge.
  - There is no same-cycle bypass.
- Pop: on a clk edge with trace_valid=1 and trace_ready=1, the head is retired.
  - trace_ready while trace_valid=0 is ignored.
  - Head outputs hold stable while trace_valid=1 and trace_ready=0.
  - When empty, head outputs show the last-read entry, or 0 after reset.
- Sequence counter:
  - Increments on every commit, whether accepted or dropped.
  - The entry carries the pre-increment value.
  - Wraps modulo 2^SEQ_W.
  - A gap in trace_seq at the host therefore marks drops.
- Full rules:
  - A push is accepted if fifo_count<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the commit is dropped: overflow is set to 1 and drop_cnt increments.
  - drop_cnt saturates at all-ones.
- Simultaneous push and pop when not full: fifo_count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from fifo_count.
- trace_clr=1 at an edge:
  - Empties the FIFO and clears overflow, drop_cnt, flow_err, flow_err_pc and the flow-check history.
  - The seq counter is NOT cleared.
  - trace_clr takes priority: a commit in the same cycle is discarded and is not counted as a drop, but seq still increments.
  - A pop in the same cycle is discarded.
- Reset mid-operation: everything returns to reset values immediately; in-flight entries are lost.

Optional Feature:
- Macro: COMMIT_TRACE_FLOW_CHECK_EN.
- Defined:
  - Holds last_pre_pc and a have_prev bit.
  - On each commit with have_prev=1 and commit_pc != last_pre_pc:
    - flow_err is set.
    - flow_err_pc captures commit_pc, first error only.
  - Every commit then updates last_pre_pc and sets have_prev.
  - have_prev is cleared by reset or trace_clr, so the first commit afterwards is never checked.
  - Dropped commits are still checked.
- Undefined: flow_err=0 and flow_err_pc=0 constant; no check registers are instantiated.

Test Plan:
- Single commit after reset: commit=1, pc=0x80000000, instr=0x00000013, pre_pc=0x80000004, trace_ready=0 -> next cycle trace_valid=1, trace_pc=0x80000000, trace_seq=0, fifo_count=1.
- Burst of 10 commits with DEPTH=8 and trace_ready=0 -> fifo_count=8, overflow=1, drop_cnt=2. Draining shows seq 0..7; the next commit gets seq=10.
- Full FIFO with trace_ready=1 and commit=1 on the same edge -> entry accepted, fifo_count stays 8, drop_cnt unchanged.
- Back-pressure hold: trace_ready toggling 0/1/0 with a continuous stream -> head fields stable during stalls; no entry lost or duplicated; order matches seq.
- Flow check, macro defined: commits pc 0x1000 (pre 0x1004), pc 0x1004 (pre 0x1008), pc 0x2000 -> flow_err=1, flow_err_pc=0x2000. A later mismatch at 0x3000 leaves flow_err_pc=0x2000. trace_clr clears both to 0.
- trace_clr with 3 entries plus a concurrent commit, then rst=0 asserted mid-stream -> after clr: fifo_count=0, overflow=0, seq advanced by 1. After rst=0: trace_seq=0, trace_valid=0, all outputs 0 asynchronously.
